// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Constants and types shared by the edge detector, its result RAM wrapper
// and the row serializer that reads the result image back out.
//   DATA_W   : pixels per image row (RAM word width)
//   ADDR_W   : result RAM address width
//   NUM_ROWS : rows in the result image (addresses 0..NUM_ROWS-1)
//   CNT_W    : width of a per-row ones count (holds 0..DATA_W)
//   ser_state_t : row serializer FSM states
// ---------------------------------------------------------------------------
package edge_pkg;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned NUM_ROWS = 49;
   localparam int unsigned CNT_W    = 7;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      SHIFT,
      ROWEND,
      DONE
   } ser_state_t;

endpackage

// File: rtl/ram_row_serializer_shifter.sv
// ---------------------------------------------------------------------------
// pixel_shifter
// Holds one image row and shifts it out LSB first, counting shifted bits
// and the number of 1-pixels seen so far in the row.
//   clk   : system clock, rising edge
//   rst   : asynchronous active-low reset
//   load  : capture data, clear bit and ones counters
//   shift : shift right by one, accumulate current pixel
//   data  : row word to load
//   pix   : current pixel (bit 0 of the shift register)
//   ones  : 1-pixels shifted out so far in this row
//   last  : the current pixel is the final one of the row
// ---------------------------------------------------------------------------
module pixel_shifter #(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CNT_W  = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] data,
   output logic              pix,
   output logic [CNT_W-1:0]  ones,
   output logic              last
);

   localparam int unsigned BIT_W = $clog2(DATA_W);

   logic [DATA_W-1:0] shreg;
   logic [BIT_W-1:0]  bitcnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg  <= '0;
         bitcnt <= '0;
         ones   <= '0;
      end else if (load) begin
         shreg  <= data;
         bitcnt <= '0;
         ones   <= '0;
      end else if (shift) begin
         shreg  <= shreg >> 1;
         bitcnt <= bitcnt + BIT_W'(1);
         ones   <= ones + CNT_W'(shreg[0]);
      end
   end

   assign pix  = shreg[0];
   assign last = (bitcnt == BIT_W'(DATA_W - 1));

endmodule

// File: rtl/ram_row_serializer.sv
// ---------------------------------------------------------------------------
// ram_row_serializer
// Reads the edge detector's result image back from RAM one row at a time
// and streams each row out as serial pixels under valid/ready, reporting
// the number of set pixels per row and a done pulse after the last row.
//   clk            : system clock, rising edge
//   rst            : asynchronous active-low reset
//   start          : one-cycle pulse, begin readout (accepted in IDLE only)
//   ram_rd_en      : RAM read request
//   ram_rd_addr    : RAM read address (row index)
//   ram_rd_data    : RAM read data, valid one cycle after ram_rd_en
//   pix_out        : current pixel, bit 0 of the row first
//   pix_valid      : pix_out holds a valid pixel
//   pix_ready      : consumer accepts the pixel
//   row_ones       : 1-pixel count of the row just completed
//   row_ones_valid : one-cycle strobe qualifying row_ones
//   busy           : readout in progress
//   done           : one-cycle pulse after the last row
// ---------------------------------------------------------------------------
module ram_row_serializer #(
   parameter int unsigned DATA_W   = edge_pkg::DATA_W,
   parameter int unsigned ADDR_W   = edge_pkg::ADDR_W,
   parameter int unsigned NUM_ROWS = edge_pkg::NUM_ROWS,
   parameter int unsigned CNT_W    = edge_pkg::CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data,
   output logic              pix_out,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [CNT_W-1:0]  row_ones,
   output logic              row_ones_valid,
   output logic              busy,
   output logic              done
);

   import edge_pkg::*;

   ser_state_t        state;
   logic [ADDR_W-1:0] row;
   logic              xfer;
   logic              pix;
   logic [CNT_W-1:0]  ones;
   logic              last;

   // pix_valid is high exactly while in SHIFT, so it doubles as the state qualifier
   assign xfer    = pix_valid & pix_ready;
   assign pix_out = pix;

   pixel_shifter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_shifter (
      .clk   (clk),
      .rst   (rst),
      .load  (state == WAIT),
      .shift (xfer),
      .data  (ram_rd_data),
      .pix   (pix),
      .ones  (ones),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         row            <= '0;
         ram_rd_en      <= 1'b0;
         ram_rd_addr    <= '0;
         pix_valid      <= 1'b0;
         row_ones       <= '0;
         row_ones_valid <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         ram_rd_en      <= 1'b0;
         row_ones_valid <= 1'b0;
         done           <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state       <= REQ;
                  ram_rd_en   <= 1'b1;
                  ram_rd_addr <= row;
                  busy        <= 1'b1;
               end
            end
            REQ: begin
               state <= WAIT;
            end
            WAIT: begin
               state     <= SHIFT;
               pix_valid <= 1'b1;
            end
            SHIFT: begin
               if (xfer && last) begin
                  // final pixel is accepted this edge, fold it into the count
                  state          <= ROWEND;
                  pix_valid      <= 1'b0;
                  row_ones       <= ones + CNT_W'(pix);
                  row_ones_valid <= 1'b1;
               end
            end
            ROWEND: begin
               if (row == ADDR_W'(NUM_ROWS - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  state       <= REQ;
                  row         <= row + ADDR_W'(1);
                  ram_rd_en   <= 1'b1;
                  ram_rd_addr <= row + ADDR_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               row   <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ram_row_serializer.sv
module tb_ram_row_serializer;

   localparam int DW = 64;
   localparam int AW = 7;
   localparam int NR = 49;
   localparam int CW = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          pix_ready = 1'b1;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data = '0;
   logic          pix_out;
   logic          pix_valid;
   logic [CW-1:0] row_ones;
   logic          row_ones_valid;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [0:127];

   int checks = 0;
   int errors = 0;

   // monitor / scoreboard state
   int   n = 0;
   int   start_n = -100000;
   bit   full_speed = 1'b1;
   logic bitq [$];
   int   onesq [$];
   int   exp_addr = 0;
   int   done_cnt = 0;
   int   rowv_cnt = 0;
   int   rden_cnt = 0;
   int   cur_row = 0;
   int   cur_bit = 0;
   int   rows_seen [0:NR-1];
   bit   prev_stall = 1'b0;
   logic prev_pix = 1'b0;

   ram_row_serializer #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_ROWS (NR),
      .CNT_W    (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .ram_rd_en      (ram_rd_en),
      .ram_rd_addr    (ram_rd_addr),
      .ram_rd_data    (ram_rd_data),
      .pix_out        (pix_out),
      .pix_valid      (pix_valid),
      .pix_ready      (pix_ready),
      .row_ones       (row_ones),
      .row_ones_valid (row_ones_valid),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // synchronous-read RAM model: data valid the cycle after the request
   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      n++;
      if (!rst) begin
         bitq.delete();
         onesq.delete();
         cur_row    = 0;
         cur_bit    = 0;
         exp_addr   = 0;
         prev_stall = 1'b0;
      end else begin
         if (start && !busy) begin
            start_n  = n;
            exp_addr = 0;
            cur_row  = 0;
            cur_bit  = 0;
            for (int r = 0; r < NR; r++) begin
               for (int b = 0; b < DW; b++) bitq.push_back(mem[r][b]);
               onesq.push_back($countones(mem[r]));
            end
         end
         if (n == start_n + 1) chk("first_rd_en", 64'(ram_rd_en), 64'd1);
         if (n == start_n + 2) chk("wait_valid_low", 64'(pix_valid), 64'd0);
         if (n == start_n + 3) chk("first_valid", 64'(pix_valid), 64'd1);
         if (prev_stall) begin
            chk("stall_valid", 64'(pix_valid), 64'd1);
            chk("stall_pix", 64'(pix_out), 64'(prev_pix));
         end
         if (ram_rd_en) begin
            rden_cnt++;
            chk("rd_addr", 64'(ram_rd_addr), 64'(exp_addr));
            exp_addr++;
         end
         if (pix_valid && pix_ready) begin
            chk("bitq_nonempty", 64'(bitq.size() != 0), 64'd1);
            if (bitq.size() != 0) chk("pix_bit", 64'(pix_out), 64'(bitq.pop_front()));
            cur_bit++;
         end
         if (row_ones_valid) begin
            chk("onesq_nonempty", 64'(onesq.size() != 0), 64'd1);
            if (onesq.size() != 0) chk("row_ones", 64'(row_ones), 64'(onesq.pop_front()));
            if (cur_row < NR) rows_seen[cur_row] = int'(row_ones);
            cur_row++;
            cur_bit = 0;
            rowv_cnt++;
         end
         if (done) begin
            done_cnt++;
            if (full_speed) chk("done_time", 64'(n), 64'(start_n + 3284));
         end
         prev_stall = pix_valid && !pix_ready;
         prev_pix   = pix_out;
      end
   end

   task automatic drive_ready(input bit rnd);
      pix_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
   endtask

   task automatic run(input int cycles, input bit rnd);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1 drive_ready(rnd);
      end
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rnd, input int target);
      for (int i = 0; i < budget; i++) begin
         if (done_cnt >= target) break;
         @(posedge clk);
         #1 drive_ready(rnd);
      end
      chk("done_reached", 64'(done_cnt), 64'(target));
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rd_en"}, 64'(ram_rd_en), 64'd0);
      chk({tag, "_valid"}, 64'(pix_valid), 64'd0);
      chk({tag, "_pix"}, 64'(pix_out), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_rov"}, 64'(row_ones_valid), 64'd0);
   endtask

   initial begin
      for (int r = 0; r < 128; r++) mem[r] = '0;
      for (int r = 0; r < NR; r++) rows_seen[r] = -1;

      // reset then idle
      repeat (3) @(posedge clk);
      #1 chk_outputs_zero("reset");
      chk("reset_row_ones", 64'(row_ones), 64'd0);
      chk("reset_addr", 64'(ram_rd_addr), 64'd0);
      rst = 1'b1;
      run(100, 1'b0);
      chk("idle_rd_en_cnt", 64'(rden_cnt), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);

      // single frame at full speed, with an ignored start while busy
      for (int r = 0; r < NR; r++) mem[r] = {32'h0, 32'(r)};
      full_speed = 1'b1;
      pulse_start();
      chk("busy_after_start", 64'(busy), 64'd1);
      run(200, 1'b0);
      pulse_start();
      wait_done(4000, 1'b0, 1);
      run(100, 1'b0);
      chk("f1_done_cnt", 64'(done_cnt), 64'd1);
      chk("f1_rowv_cnt", 64'(rowv_cnt), 64'd49);
      chk("f1_rden_cnt", 64'(rden_cnt), 64'd49);
      chk("f1_bitq_empty", 64'(bitq.size()), 64'd0);
      chk("f1_row3", 64'(rows_seen[3]), 64'd2);
      chk("f1_row7", 64'(rows_seen[7]), 64'd3);
      chk("f1_row48", 64'(rows_seen[48]), 64'd2);
      chk("f1_busy_end", 64'(busy), 64'd0);

      // extreme rows
      mem[0] = 64'h0;
      mem[1] = 64'hFFFF_FFFF_FFFF_FFFF;
      rowv_cnt = 0;
      pulse_start();
      wait_done(4000, 1'b0, 2);
      run(5, 1'b0);
      chk("f2_row0_zero", 64'(rows_seen[0]), 64'd0);
      chk("f2_row1_full", 64'(rows_seen[1]), 64'd64);
      chk("f2_rowv_cnt", 64'(rowv_cnt), 64'd49);

      // backpressure
      mem[5] = 64'hA5A5_A5A5_A5A5_A5A5;
      full_speed = 1'b0;
      rowv_cnt = 0;
      pulse_start();
      wait_done(30000, 1'b1, 3);
      pix_ready = 1'b1;
      run(5, 1'b0);
      chk("f3_row5", 64'(rows_seen[5]), 64'd32);
      chk("f3_rowv_cnt", 64'(rowv_cnt), 64'd49);
      chk("f3_bitq_empty", 64'(bitq.size()), 64'd0);

      // reset mid-row 20, bit 17
      full_speed = 1'b1;
      pulse_start();
      for (int i = 0; i < 3000; i++) begin
         if (cur_row == 20 && cur_bit == 17) break;
         run(1, 1'b0);
      end
      chk("f4_reached_row", 64'(cur_row), 64'd20);
      chk("f4_reached_bit", 64'(cur_bit), 64'd17);
      rowv_cnt = 0;
      #2 rst = 1'b0;
      #1 chk_outputs_zero("midreset");
      run(3, 1'b0);
      rst = 1'b1;
      run(3, 1'b0);
      chk("f4_no_done", 64'(done_cnt), 64'd3);
      chk("f4_no_rowv", 64'(rowv_cnt), 64'd0);
      for (int r = 0; r < NR; r++) rows_seen[r] = -1;
      mem[20] = 64'h8000_0000_0001_00F0;
      pulse_start();
      wait_done(4000, 1'b0, 4);
      run(5, 1'b0);
      chk("f4_rowv_cnt", 64'(rowv_cnt), 64'd49);
      chk("f4_row0", 64'(rows_seen[0]), 64'd0);
      chk("f4_row20", 64'(rows_seen[20]), 64'd6);
      chk("f4_bitq_empty", 64'(bitq.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_row_serializer.md
Name: ram_row_serializer

Overview:
- Downstream stage of the edge detector.
- After the edge detector has written its result image into RAM (rows 0..48, 64 bits each), this block reads the rows back one at a time and shifts each row out as a serial pixel stream under a valid/ready handshake.
- Per row, it reports the count of set pixels.
- Feeds the display/UART output path and gives the control logic a done indication.

Parameters:
- DATA_W, 64, pixels per row (RAM word width)
- ADDR_W, 7, RAM address width
- NUM_ROWS, 49, rows to read, addresses 0..NUM_ROWS-1
- CNT_W, 7, width of per-row ones count (must hold 0..DATA_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin readout of rows 0..NUM_ROWS-1
- ram_rd_en  out  1  RAM read request
- ram_rd_addr  out  ADDR_W  RAM read address
- ram_rd_data  in  DATA_W  RAM read data, valid one cycle after ram_rd_en
- pix_out  out  1  current pixel, bit 0 of row first
- pix_valid  out  1  pix_out holds a valid pixel
- pix_ready  in  1  consumer accepts pixel (transfer = pix_valid & pix_ready)
- row_ones  out  CNT_W  number of 1-pixels in the row just completed
- row_ones_valid  out  1  one-cycle strobe qualifying row_ones
- busy  out  1  high from the cycle after start until DONE is left
- done  out  1  one-cycle pulse after the last row completes

Behaviour:
- Reset (rst low, async): state IDLE, row=0, all outputs 0, shift register and counters cleared. Deassertion is synchronous to clk (external sync).
- FSM states and transitions:
  - IDLE: start=1 -> REQ; otherwise stay. busy=0.
  - REQ: ram_rd_en=1, ram_rd_addr=row. Next state WAIT.
  - WAIT: ram_rd_en=0. At the end of the cycle, shreg <= ram_rd_data, bitcnt <= 0, ones <= 0. Next state SHIFT.
  - SHIFT: pix_valid=1, pix_out=shreg[0].
    - On each transfer: shreg shifts right by 1, ones += pix_out, bitcnt += 1.
    - After the transfer with bitcnt==DATA_W-1 -> ROWEND.
    - No transfer -> hold everything.
  - ROWEND: pix_valid=0, row_ones_valid=1, row_ones=ones.
    - If row==NUM_ROWS-1 -> DONE.
    - Otherwise row += 1 -> REQ.
  - DONE: done=1 for one cycle, row <= 0 -> IDLE.
- Handshake:
  - Once pix_valid rises, it must not fall, and pix_out must not change, until a transfer occurs.
  - pix_ready may toggle freely; stalls of any length are legal.
- Latency:
  - start sampled at edge k -> ram_rd_en high in cycle k+1 -> first pix_valid in cycle k+3.
  - With pix_ready tied high, each row takes 67 cycles (REQ + WAIT + 64 SHIFT + ROWEND).
  - Full frame takes 49×67 = 3283 cycles, plus 1 DONE cycle.
- Arithmetic:
  - ones counts 0..64 in CNT_W bits and never saturates or wraps at these parameters.
  - row counts 0..NUM_ROWS-1 in ADDR_W bits.
- Boundaries:
  - start while busy (any state except IDLE): ignored.
  - start in the same cycle as DONE: ignored. A new start is accepted from IDLE only.
  - An all-zero row gives row_ones=0; an all-ones row gives row_ones=64.
  - Reset mid-row: immediate return to IDLE, pix_valid=0, no row_ones_valid or done pulse.
  - ram_rd_data is sampled only in WAIT. Its value in other cycles is don't-care.

Decomposition:
- Shared package edge_pkg:
  - constants DATA_W, ADDR_W, NUM_ROWS, CNT_W (shared with the edge detector and RAM wrapper)
  - state enum ser_state_t {IDLE, REQ, WAIT, SHIFT, ROWEND, DONE}
- One sub-module, pixel_shifter: holds the DATA_W shift register, bit counter and ones counter, with load/shift controls and a last-bit flag.
- The FSM, row counter and RAM interface stay in ram_row_serializer.

Test Plan:
- Reset then idle: rst low for 3 cycles, start=0 -> all outputs 0, busy=0, no ram_rd_en for 100 cycles.
- Single frame, pix_ready=1:
  - RAM row r = {32'h0, 32'(r)}; pulse start at cycle 10.
  - ram_rd_en/addr 0 at cycle 11, pix_valid from cycle 13.
  - Serial bits equal r, LSB first.
  - row_ones = popcount(r) per row (row 3 -> 2, row 7 -> 3).
  - done pulses at cycle 10+3283+1; 49 row_ones_valid strobes total.
- Extreme rows:
  - row 0 = 64'h0, row 1 = 64'hFFFF_FFFF_FFFF_FFFF.
  - row_ones = 0 then 64; no wrap.
- Backpressure:
  - Random pix_ready, 30% high, row 5 = 64'hA5A5_A5A5_A5A5_A5A5.
  - Bit stream is 1,0,1,0,0,1,0,1,... with no loss or duplication; row_ones=32.
  - pix_out stable while valid & !ready.
- Start while busy: second start pulse at cycle 200 -> ignored; exactly one done, row sequence 0..48 unchanged.
- Reset mid-operation:
  - rst low during row 20, bit 17, then release and pulse start.
  - Outputs clear immediately, no done pulse.
  - Readout restarts at address 0 with correct data.
